// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: multi-cycle RV32I branch resolver time-sharing one adder for compare then next-PC.
// Optional retire statistics behind BRANCH_STATS_EN (counters tied to 0 when undefined).
module branch_resolve_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  instr,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  next_pc,
  output logic             misalign,
  output logic [CNT_W-1:0] stat_total,
  output logic [CNT_W-1:0] stat_taken
);
  localparam logic [1:0] IDLE = 2'd0, CMP = 2'd1, TGT = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d, pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, next_pc_q, next_pc_d;
  logic taken_q, taken_d, misalign_q, misalign_d;
  logic accept, handshake, is_sb, eq, lt, ltu, cond, add_ci, unused_instr;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_b, add_a, add_b, add_s;

  assign in_ready = (state_q == IDLE || (state_q == DONE && out_ready)) && !flush;
  assign accept = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign handshake = out_valid && out_ready && !flush;
  assign taken = taken_q;
  assign next_pc = next_pc_q;
  assign misalign = misalign_q;
  assign f3 = instr_q[14:12];
  assign is_sb = instr_q[6:0] == 7'b1100011;
  assign imm_b = {{(XLEN-12){instr_q[XLEN-1]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign unused_instr = ^instr_q[24:15];
  // shared adder: rs1 + ~rs2 + 1 while comparing, pc + offset while forming the target
  assign add_a = state_q == CMP ? rs1_q : pc_q;
  assign add_b = state_q == CMP ? ~rs2_q : (taken_q ? imm_b : XLEN'(4));
  assign add_ci = state_q == CMP;
  assign add_s = add_a + add_b + XLEN'(add_ci);
  assign eq = add_s == '0;
  assign lt = (rs1_q[XLEN-1] & ~rs2_q[XLEN-1]) | ((rs1_q[XLEN-1] ~^ rs2_q[XLEN-1]) & add_s[XLEN-1]);
  assign ltu = (~rs1_q[XLEN-1] & rs2_q[XLEN-1]) | ((rs1_q[XLEN-1] ~^ rs2_q[XLEN-1]) & add_s[XLEN-1]);
  assign cond = f3[2:1] == 2'b00 ? eq : f3[2:1] == 2'b10 ? lt : ltu;

  always_comb begin
    instr_d = instr_q;
    pc_d = pc_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (accept) begin
      instr_d = instr;
      pc_d = pc;
      rs1_d = rs1_data;
      rs2_d = rs2_data;
    end
    taken_d = state_q == CMP ? is_sb && f3[2:1] != 2'b01 && (cond ^ f3[0]) : taken_q;
    next_pc_d = state_q == TGT ? add_s : next_pc_q;
    misalign_d = state_q == TGT ? add_s[1] : misalign_q;
    state_d = flush ? IDLE :
              accept ? CMP :
              state_q == CMP ? TGT :
              state_q == TGT ? DONE :
              (state_q == DONE && out_ready) ? IDLE : state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      pc_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      taken_q <= 1'b0;
      next_pc_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q <= pc_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      taken_q <= taken_d;
      next_pc_q <= next_pc_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] stat_total_q, stat_total_d, stat_taken_q, stat_taken_d;
  // only SB-type retirements count; both counters stick at all-ones
  assign stat_total_d = (handshake && is_sb && stat_total_q != '1) ? stat_total_q + 1'b1 : stat_total_q;
  assign stat_taken_d = (handshake && is_sb && taken_q && stat_taken_q != '1) ? stat_taken_q + 1'b1 : stat_taken_q;
  assign stat_total = stat_total_q;
  assign stat_taken = stat_taken_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_total_q <= '0;
      stat_taken_q <= '0;
    end else begin
      stat_total_q <= stat_total_d;
      stat_taken_q <= stat_taken_d;
    end
  end
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
  assign stat_total = '0;
  assign stat_taken = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed literal cases plus randomized traffic checked against a transaction-level model.
module tb_branch_resolve_ctrl;
  localparam int CNT_W = 4;
  localparam int SMAX = (1 << CNT_W) - 1;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, taken, misalign;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0, next_pc, r;
  logic [CNT_W-1:0] stat_total, stat_taken;
  int checks = 0, errors = 0, lat;
  bit m_busy, m_sb, m_taken, mv, mr;
  int m_age, m_tot, m_tkn;
  logic [31:0] m_npc;

  branch_resolve_ctrl #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .next_pc(next_pc),
    .misalign(misalign), .stat_total(stat_total), .stat_taken(stat_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] b_instr(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // reference: signed/unsigned compares and plain 32-bit addition
  function automatic logic [32:0] ref_branch(input logic [31:0] i, input logic [31:0] p,
                                             input logic [31:0] a, input logic [31:0] b);
    logic signed [12:0] off;
    bit t;
    off = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    case (i[14:12])
      3'd0: t = a == b;
      3'd1: t = a != b;
      3'd4: t = $signed(a) < $signed(b);
      3'd5: t = $signed(a) >= $signed(b);
      3'd6: t = a < b;
      3'd7: t = a >= b;
      default: t = 1'b0;
    endcase
    if (i[6:0] != 7'h63) t = 1'b0;
    return {t, p + (t ? 32'(int'(off)) : 32'd4)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_age = 0; m_tot = 0; m_tkn = 0;
    end else begin
      mv = m_busy && m_age >= 2;
      mr = (!m_busy || (mv && out_ready)) && !flush;
      if (flush) m_busy = 0;
      else begin
        if (mv && out_ready) begin
          m_busy = 0;
          if (m_sb) begin
            m_tot = m_tot < SMAX ? m_tot + 1 : m_tot;
            if (m_taken) m_tkn = m_tkn < SMAX ? m_tkn + 1 : m_tkn;
          end
        end else if (m_busy) m_age++;
        if (in_valid && mr) begin
          {m_taken, m_npc} = ref_branch(instr, pc, rs1_data, rs2_data);
          m_sb = instr[6:0] == 7'h63;
          m_busy = 1; m_age = 0;
        end
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("out_valid", 32'(out_valid), 32'(m_busy && m_age >= 2));
    chk("in_ready", 32'(in_ready), 32'((!m_busy || (m_age >= 2 && out_ready)) && !flush));
    if (m_busy && m_age >= 2) begin
      chk("taken", 32'(taken), 32'(m_taken));
      chk("next_pc", next_pc, m_npc);
      chk("misalign", 32'(misalign), 32'(m_npc[1]));
    end
    chk("stat_total", 32'(stat_total), STATS ? 32'(m_tot) : 32'd0);
    chk("stat_taken", 32'(stat_taken), STATS ? 32'(m_tkn) : 32'd0);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    instr = i; pc = p; rs1_data = a; rs2_data = b; in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!ok) chk("accept timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic expect_res(input string tag, input int n, input bit et, input logic [31:0] enpc, input bit em);
    chk({tag, " latency"}, 32'(n), 32'd3);
    chk({tag, " taken"}, 32'(taken), 32'(et));
    chk({tag, " next_pc"}, next_pc, enpc);
    chk({tag, " misalign"}, 32'(misalign), 32'(em));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset taken", 32'(taken), 32'd0);
    chk("reset next_pc", next_pc, 32'd0);
    chk("reset misalign", 32'(misalign), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    step();
    out_ready = 1'b1;
    send(b_instr(3'd0, 13'd16), 32'h100, 32'd5, 32'd5);
    wait_valid(lat); expect_res("beq", lat, 1, 32'h110, 0); step();
    send(b_instr(3'd4, 13'd8), 32'h200, 32'hFFFFFFFF, 32'd1);
    wait_valid(lat); expect_res("blt", lat, 1, 32'h208, 0); step();
    send(b_instr(3'd6, 13'd8), 32'h200, 32'hFFFFFFFF, 32'd1);
    wait_valid(lat); expect_res("bltu", lat, 0, 32'h204, 0); step();
    out_ready = 1'b0;
    send(b_instr(3'd1, 13'h1FFC), 32'h300, 32'd1, 32'd2);
    wait_valid(lat); expect_res("bne back", lat, 1, 32'h2FC, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall next_pc", next_pc, 32'h2FC);
      chk("stall in_ready", 32'(in_ready), 32'd0);
    end
    step();
    out_ready = 1'b1;
    send(b_instr(3'd5, 13'd32), 32'h400, 32'd3, 32'd3);
    wait_valid(lat); expect_res("bge b2b", lat, 1, 32'h420, 0); step();
    send(b_instr(3'd0, 13'd16), 32'h500, 32'd7, 32'd7);
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("flush in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("flushed out_valid", 32'(out_valid), 32'd0);
    end
    chk("flush stat_total", 32'(stat_total), STATS ? 32'd5 : 32'd0);
    chk("flush stat_taken", 32'(stat_taken), STATS ? 32'd4 : 32'd0);
    step();
    send(b_instr(3'd1, 13'd16), 32'hFFFFFFFC, 32'd9, 32'd9);
    wait_valid(lat); expect_res("bne wrap", lat, 0, 32'h0, 0); step();
    send(b_instr(3'd0, 13'd2), 32'h100, 32'd9, 32'd9);
    wait_valid(lat); expect_res("beq misalign", lat, 1, 32'h102, 1); step();
    send(32'h00000013, 32'h600, 32'd1, 32'd1);
    wait_valid(lat); expect_res("addi", lat, 0, 32'h604, 0); step();
    send(b_instr(3'd0, 13'd16), 32'h700, 32'd1, 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst next_pc", next_pc, 32'd0);
    chk("midrst taken", 32'(taken), 32'd0);
    chk("midrst stat_total", 32'(stat_total), 32'd0);
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 20; k++) begin
      send(b_instr(3'd0, 13'd8), 32'h800, 32'(k), 32'(k));
      wait_valid(lat);
      step();
    end
    @(negedge clk);
    chk("sat stat_total", 32'(stat_total), STATS ? 32'd15 : 32'd0);
    chk("sat stat_taken", 32'(stat_taken), STATS ? 32'd15 : 32'd0);
    step();
    send(32'h00000033, 32'h900, 32'd4, 32'd4);
    wait_valid(lat); expect_res("add", lat, 0, 32'h904, 0); step();
    @(negedge clk);
    chk("nonbranch stat_total", 32'(stat_total), STATS ? 32'd15 : 32'd0);
    step();
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 25) == 0;
      rs1_data = $urandom;
      rs2_data = ($urandom % 3 == 0) ? rs1_data : (($urandom % 2 == 0) ? (rs1_data ^ 32'h80000000) : $urandom);
      r = $urandom;
      instr = ($urandom % 8 == 0) ? r : {r[31:7], 7'h63};
      pc = $urandom;
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
